// File: rtl/hack_boot_run_controller_if.sv
// Signal bundle between the boot/run controller and the FPGA top level.
// The controller uses the master view; the top level, or a test environment, uses the slave view.
interface hack_boot_run_controller_if;
    logic       pll_locked;
    logic       loader_done;
    logic       btn_reset_strobe;
    logic       btn_pause_strobe;
    logic       btn_step_strobe;
    logic       loader_run;
    logic       cpu_reset;
    logic       cpu_clk_en;
    logic       load_error;
    logic [7:0] boot_count;
    logic [2:0] state;

    modport master (
        input  pll_locked,
        input  loader_done,
        input  btn_reset_strobe,
        input  btn_pause_strobe,
        input  btn_step_strobe,
        output loader_run,
        output cpu_reset,
        output cpu_clk_en,
        output load_error,
        output boot_count,
        output state
    );

    modport slave (
        output pll_locked,
        output loader_done,
        output btn_reset_strobe,
        output btn_pause_strobe,
        output btn_step_strobe,
        input  loader_run,
        input  cpu_reset,
        input  cpu_clk_en,
        input  load_error,
        input  boot_count,
        input  state
    );
endinterface

// File: rtl/hack_boot_run_controller.sv
// SoC bring-up sequencer: PLL lock settle, ROM load, CPU reset hold, then run/pause/step control.
// All outputs are registered and are derived from the next state, so there is no input-to-output path.
module hack_boot_run_controller #(
    parameter int unsigned STARTUP_DELAY       = 16,
    parameter int unsigned POST_LOAD_HOLD      = 8,
    parameter int unsigned LOAD_TIMEOUT_CYCLES = 1048576
) (
    input  logic                              clk,
    input  logic                              reset_n,
    hack_boot_run_controller_if.master        bus
);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_SETTLE    = 3'd1,
        S_LOAD      = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4,
        S_PAUSE     = 3'd5,
        S_ERROR     = 3'd6
    } state_e;

    localparam int unsigned CW = 24;
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(STARTUP_DELAY - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(POST_LOAD_HOLD - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOAD_TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          loader_run_q, loader_run_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          cpu_clk_en_q, cpu_clk_en_d;
    logic          load_error_q, load_error_d;
    logic [7:0]    boot_count_q, boot_count_d;
    logic          step_pulse;

    // Shared counter: settle length in SETTLE, timeout in LOAD, hold length in HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_WAIT_LOCK;
            cnt_q        <= '0;
            loader_run_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
            cpu_clk_en_q <= 1'b0;
            load_error_q <= 1'b0;
            boot_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loader_run_q <= loader_run_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            load_error_q <= load_error_d;
            boot_count_q <= boot_count_d;
        end
    end

    // Loader handshake: loader_run rises on LOAD entry and stays high until loader_done is
    // sampled high in LOAD; it then drops on the next edge. loader_done outside LOAD is ignored.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_error_d = load_error_q;
        boot_count_d = boot_count_q;
        step_pulse   = 1'b0;

        if (!bus.pll_locked) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_LOAD: begin
                    if (bus.loader_done) begin
                        state_d      = S_HOLD;
                        cnt_d        = '0;
                        load_error_d = 1'b0;
                        if (boot_count_q != 8'hFF) begin
                            boot_count_d = boot_count_q + 8'd1;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d      = S_ERROR;
                        cnt_d        = '0;
                        load_error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.btn_reset_strobe) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    if (bus.btn_reset_strobe) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else if (bus.btn_pause_strobe) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (bus.btn_reset_strobe) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else if (bus.btn_pause_strobe) begin
                        state_d = S_RUN;
                    end else if (bus.btn_step_strobe) begin
                        step_pulse = 1'b1;
                    end
                end
                S_ERROR: begin
                    if (bus.btn_reset_strobe) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end

        loader_run_d = (state_d == S_LOAD);
        cpu_reset_d  = !((state_d == S_RUN) || (state_d == S_PAUSE));
        cpu_clk_en_d = (state_d == S_RUN) || step_pulse;
    end

    assign bus.loader_run = loader_run_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.cpu_clk_en = cpu_clk_en_q;
    assign bus.load_error = load_error_q;
    assign bus.boot_count = boot_count_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_hack_boot_run_controller.sv
// Directed bench for the boot/run controller: bring-up, timeout/retry, pause/step, lock loss, async reset.
module tb_hack_boot_run_controller;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   pulses;
    int   highs;

    hack_boot_run_controller_if bus ();

    hack_boot_run_controller #(
        .STARTUP_DELAY       (16),
        .POST_LOAD_HOLD      (8),
        .LOAD_TIMEOUT_CYCLES (100)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input int st, input int lr, input int cr, input int ce);
        check_eq({tag, ".state"},      32'(bus.state),      32'(st));
        check_eq({tag, ".loader_run"}, 32'(bus.loader_run), 32'(lr));
        check_eq({tag, ".cpu_reset"},  32'(bus.cpu_reset),  32'(cr));
        check_eq({tag, ".cpu_clk_en"}, 32'(bus.cpu_clk_en), 32'(ce));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.loader_done = 1'b0;
        bus.btn_reset_strobe = 1'b0;
        bus.btn_pause_strobe = 1'b0;
        bus.btn_step_strobe = 1'b0;

        cyc(1);
        expect_outs("reset", 0, 0, 1, 0);
        check_eq("reset.boot_count", 32'(bus.boot_count), 32'd0);
        check_eq("reset.load_error", 32'(bus.load_error), 32'd0);
        cyc(1);
        reset_n = 1'b1;

        // Bring-up: lock at cycle 5, 16 settle cycles, load done after 40 cycles, 8 hold cycles.
        cyc(4);
        bus.pll_locked = 1'b1;
        cyc(1);
        expect_outs("t1_settle_entry", 1, 0, 1, 0);
        cyc(15);
        expect_outs("t1_settle_end", 1, 0, 1, 0);
        cyc(1);
        expect_outs("t1_load_entry", 2, 1, 1, 0);
        cyc(39);
        expect_outs("t1_load_wait", 2, 1, 1, 0);
        bus.loader_done = 1'b1;
        cyc(1);
        bus.loader_done = 1'b0;
        expect_outs("t1_hold_entry", 3, 0, 1, 0);
        check_eq("t1_boot_count", 32'(bus.boot_count), 32'd1);
        cyc(7);
        expect_outs("t1_hold_end", 3, 0, 1, 0);
        cyc(1);
        expect_outs("t1_run", 4, 0, 0, 1);

        // In RUN: stray loader_done and step strobes are ignored.
        bus.loader_done = 1'b1;
        cyc(2);
        bus.loader_done = 1'b0;
        check_eq("run_done_ignored.boot_count", 32'(bus.boot_count), 32'd1);
        bus.btn_step_strobe = 1'b1;
        cyc(1);
        bus.btn_step_strobe = 1'b0;
        expect_outs("run_step_ignored", 4, 0, 0, 1);

        // Pause and three single steps five cycles apart.
        bus.btn_pause_strobe = 1'b1;
        cyc(1);
        bus.btn_pause_strobe = 1'b0;
        expect_outs("t3_pause", 5, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            bus.btn_step_strobe = (i % 5 == 0);
            cyc(1);
            bus.btn_step_strobe = 1'b0;
            if (bus.cpu_clk_en) pulses++;
            check_eq("t3_step_en", 32'(bus.cpu_clk_en), 32'(i % 5 == 0));
        end
        check_eq("t3_pulse_count", 32'(pulses), 32'd3);
        check_eq("t3_still_paused", 32'(bus.state), 32'd5);
        bus.btn_pause_strobe = 1'b1;
        cyc(1);
        bus.btn_pause_strobe = 1'b0;
        expect_outs("t3_resume", 4, 0, 0, 1);
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (bus.cpu_clk_en) highs++;
        end
        check_eq("t3_run_continuous", 32'(highs), 32'd5);

        // Reset and pause strobes together in RUN: reset wins, back to RUN after the hold.
        bus.btn_reset_strobe = 1'b1;
        bus.btn_pause_strobe = 1'b1;
        cyc(1);
        bus.btn_reset_strobe = 1'b0;
        bus.btn_pause_strobe = 1'b0;
        expect_outs("t5_hold", 3, 0, 1, 0);
        cyc(7);
        expect_outs("t5_hold_end", 3, 0, 1, 0);
        cyc(1);
        expect_outs("t5_run", 4, 0, 0, 1);
        check_eq("t5_boot_count", 32'(bus.boot_count), 32'd1);

        // Lock lost for one cycle in RUN (with a pause strobe) and again in LOAD.
        bus.pll_locked = 1'b0;
        bus.btn_pause_strobe = 1'b1;
        cyc(1);
        bus.pll_locked = 1'b1;
        bus.btn_pause_strobe = 1'b0;
        expect_outs("t4_run_drop", 0, 0, 1, 0);
        cyc(1);
        expect_outs("t4_resettle", 1, 0, 1, 0);
        cyc(15);
        expect_outs("t4_resettle_end", 1, 0, 1, 0);
        cyc(1);
        expect_outs("t4_reload", 2, 1, 1, 0);
        cyc(3);
        bus.pll_locked = 1'b0;
        cyc(1);
        bus.pll_locked = 1'b1;
        expect_outs("t4_load_drop", 0, 0, 1, 0);
        cyc(1);
        expect_outs("t4_resettle2", 1, 0, 1, 0);
        cyc(16);
        expect_outs("t4_reload2", 2, 1, 1, 0);
        bus.loader_done = 1'b1;
        cyc(1);
        bus.loader_done = 1'b0;
        expect_outs("t4_hold", 3, 0, 1, 0);
        check_eq("t4_boot_count", 32'(bus.boot_count), 32'd2);
        cyc(8);
        expect_outs("t4_run", 4, 0, 0, 1);

        // Load timeout after 100 LOAD cycles, then retry via reset strobe.
        bus.pll_locked = 1'b0;
        cyc(1);
        bus.pll_locked = 1'b1;
        expect_outs("t2_drop", 0, 0, 1, 0);
        cyc(1);
        cyc(16);
        expect_outs("t2_load_entry", 2, 1, 1, 0);
        cyc(99);
        expect_outs("t2_load_last", 2, 1, 1, 0);
        cyc(1);
        expect_outs("t2_error", 6, 0, 1, 0);
        check_eq("t2_load_error", 32'(bus.load_error), 32'd1);
        check_eq("t2_boot_count", 32'(bus.boot_count), 32'd2);
        cyc(3);
        check_eq("t2_error_sticky", 32'(bus.state), 32'd6);
        bus.btn_reset_strobe = 1'b1;
        cyc(1);
        bus.btn_reset_strobe = 1'b0;
        expect_outs("t2_retry_settle", 1, 0, 1, 0);
        check_eq("t2_retry_load_error", 32'(bus.load_error), 32'd1);
        cyc(15);
        expect_outs("t2_retry_settle_end", 1, 0, 1, 0);
        cyc(1);
        expect_outs("t2_retry_load", 2, 1, 1, 0);
        bus.btn_reset_strobe = 1'b1;
        cyc(1);
        bus.btn_reset_strobe = 1'b0;
        expect_outs("t2_load_reset_ignored", 2, 1, 1, 0);
        bus.loader_done = 1'b1;
        cyc(1);
        bus.loader_done = 1'b0;
        expect_outs("t2_hold", 3, 0, 1, 0);
        check_eq("t2_load_error_cleared", 32'(bus.load_error), 32'd0);
        check_eq("t2_boot_count_after", 32'(bus.boot_count), 32'd3);
        cyc(8);
        expect_outs("t2_run", 4, 0, 0, 1);

        // Asynchronous reset mid-PAUSE and mid-LOAD.
        bus.btn_pause_strobe = 1'b1;
        cyc(1);
        bus.btn_pause_strobe = 1'b0;
        expect_outs("t6_pause", 5, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        expect_outs("t6_pause_reset", 0, 0, 1, 0);
        check_eq("t6_pause_reset.boot_count", 32'(bus.boot_count), 32'd0);
        check_eq("t6_pause_reset.load_error", 32'(bus.load_error), 32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        expect_outs("t6_settle", 1, 0, 1, 0);
        cyc(16);
        expect_outs("t6_load", 2, 1, 1, 0);
        cyc(5);
        reset_n = 1'b0;
        #1;
        expect_outs("t6_load_reset", 0, 0, 1, 0);
        check_eq("t6_load_reset.boot_count", 32'(bus.boot_count), 32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        expect_outs("t6_recover", 1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
